// File: rtl/i2s_dual_rx.sv
// Two-channel I2S receiver: MIC1 (left slot) -> o_d, MIC2 (right slot) -> o_x, oversampled on i_clk.
// Optional macro I2S_RX_FRAME_CHECK_EN adds slot-length checking with o_err reporting.
module i2s_dual_rx #(
    parameter int NB_DATA   = 32,
    parameter int NB_SAMPLE = 24,
    parameter int NB_SLOT   = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_sck,
    input  logic               i_ws,
    input  logic               i_sd,
    output logic [NB_DATA-1:0] o_d,
    output logic [NB_DATA-1:0] o_x,
    output logic               o_valid,
    output logic               o_err
);

    localparam int CW = $clog2(NB_SAMPLE + 1);
    localparam logic [CW-1:0] SAMP_FULL = CW'(NB_SAMPLE);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_LEFT,
        ST_RIGHT
    } state_t;

    state_t state, state_nxt;

    logic [1:0] sck_sy, ws_sy, sd_sy;
    logic       sck_d, ws_prev;
    logic       sck_rise, ws_rise, ws_fall, ws_chg;

    logic [NB_SLOT-1:0]   sr;
    logic [NB_SLOT:0]     cat;
    logic [CW-1:0]        bit_cnt, fill;
    logic [NB_SAMPLE-1:0] samp, word_cur;

    logic lft_cap, pair_end, frame_bad;

    logic                        vld_p0, err_p0, lft_p0;
    logic [NB_SAMPLE-1:0]        word_p0;
    logic                        vld_p1, err_p1;
    logic signed [NB_DATA-1:0]   mic1_p1, mic2_p1;

    // Places the first received slot bits at the top of the sample, zero-filling missing LSBs.
    function automatic logic [NB_SAMPLE-1:0] pack_word(input logic [NB_SLOT:0] c,
                                                       input logic [CW-1:0]    sh);
        return NB_SAMPLE'(c << sh);
    endfunction

    function automatic logic signed [NB_DATA-1:0] sign_extend(input logic [NB_SAMPLE-1:0] w);
        logic signed [NB_SAMPLE-1:0] s;
        s = w;
        return NB_DATA'(s);
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sck_sy  <= '0;
            ws_sy   <= '0;
            sd_sy   <= '0;
            sck_d   <= 1'b0;
            ws_prev <= 1'b0;
        end else begin
            sck_sy <= {sck_sy[0], i_sck};
            ws_sy  <= {ws_sy[0], i_ws};
            sd_sy  <= {sd_sy[0], i_sd};
            sck_d  <= sck_sy[1];
            if (sck_rise) begin
                ws_prev <= ws_sy[1];
            end
        end
    end

    assign sck_rise = sck_sy[1] & ~sck_d;
    assign ws_rise  = sck_rise & ws_sy[1] & ~ws_prev;
    assign ws_fall  = sck_rise & ~ws_sy[1] & ws_prev;
    assign ws_chg   = ws_rise | ws_fall;

    // bit_cnt counts bits of the current slot and saturates once the sample is complete.
    assign cat      = {sr, sd_sy[1]};
    assign fill     = (bit_cnt == SAMP_FULL) ? SAMP_FULL : bit_cnt + 1'b1;
    assign word_cur = (bit_cnt == SAMP_FULL) ? samp : pack_word(cat, SAMP_FULL - fill);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (sck_rise) begin
            sr <= cat[NB_SLOT-1:0];
            if (ws_chg) begin
                bit_cnt <= '0;
            end else if (bit_cnt != SAMP_FULL) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (sck_rise && (bit_cnt == SAMP_FULL - 1'b1)) begin
            samp <= NB_SAMPLE'(cat);
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    localparam int SW = $clog2(NB_SLOT + 1);
    localparam logic [SW-1:0] SLOT_FULL = SW'(NB_SLOT);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NB_SLOT - 1);

    logic [SW-1:0] slot_cnt;
    logic          pair_bad, slot_bad;

    // A slot is good when the edge carrying the ws change is its NB_SLOT-th bit.
    assign slot_bad  = (slot_cnt != SLOT_LAST);
    assign frame_bad = pair_bad | slot_bad;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            slot_cnt <= '0;
            pair_bad <= 1'b0;
        end else begin
            if (sck_rise) begin
                if (ws_chg) begin
                    slot_cnt <= '0;
                end else if (slot_cnt != SLOT_FULL) begin
                    slot_cnt <= slot_cnt + 1'b1;
                end
            end
            if (lft_cap) begin
                pair_bad <= slot_bad;
            end
        end
    end
`else
    assign frame_bad = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lft_cap   = 1'b0;
        pair_end  = 1'b0;
        case (state)
            ST_SYNC: begin
                if (ws_fall) begin
                    state_nxt = ST_LEFT;
                end
            end
            ST_LEFT: begin
                if (ws_rise) begin
                    state_nxt = ST_RIGHT;
                    lft_cap   = 1'b1;
                end
            end
            ST_RIGHT: begin
                if (ws_fall) begin
                    state_nxt = ST_LEFT;
                    pair_end  = 1'b1;
                end
            end
            default: state_nxt = ST_SYNC;
        endcase
    end

    // Stage p0: completed slot word registered on the sck edge that closed it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p0 <= 1'b0;
            err_p0 <= 1'b0;
            lft_p0 <= 1'b0;
        end else begin
            vld_p0 <= pair_end & ~frame_bad;
            err_p0 <= pair_end & frame_bad;
            lft_p0 <= lft_cap;
        end
    end

    always_ff @(posedge i_clk) begin
        if (pair_end | lft_cap) begin
            word_p0 <= word_cur;
        end
    end

    // Stage p1: sign extension; the left word is held here until its right partner arrives.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            err_p1 <= err_p0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (lft_p0) begin
            mic1_p1 <= sign_extend(word_p0);
        end
        if (vld_p0) begin
            mic2_p1 <= sign_extend(word_p0);
        end
    end

    // Stage p2: output pair register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            o_d     <= '0;
            o_x     <= '0;
        end else begin
            o_valid <= vld_p1;
            o_err   <= err_p1;
            if (vld_p1) begin
                o_d <= mic1_p1;
                o_x <= mic2_p1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_dual_rx.sv
// Directed bench for i2s_dual_rx: vector table of left/right words plus sync, reset and slot-length sequences.
// Builds against either setting of I2S_RX_FRAME_CHECK_EN.
module tb_i2s_dual_rx;

    logic        tb_clk = 1'b0;
    logic        rst;
    logic        sck, ws, sd;
    logic [31:0] o_d, o_x;
    logic        o_valid, o_err;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [31:0] d;
        logic [31:0] x;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [31:0] x;
        int          lat;
    } cap_t;

    vec_t        vecs[6];
    cap_t        capq[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_rise = 0;
    int          err_cnt = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] last_d = '0;
    logic [31:0] last_x = '0;

    i2s_dual_rx dut (
        .i_clk  (tb_clk),
        .i_rst  (rst),
        .i_sck  (sck),
        .i_ws   (ws),
        .i_sd   (sd),
        .o_d    (o_d),
        .o_x    (o_x),
        .o_valid(o_valid),
        .o_err  (o_err)
    );

    always #10 tb_clk = ~tb_clk;

    always @(posedge tb_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    always @(negedge tb_clk) begin
        if (o_valid) begin
            check("valid_gap", {31'b0, prev_valid}, 32'd0);
            capq.push_back('{d: o_d, x: o_x, lat: cyc - last_rise});
        end
        if (o_err) err_cnt++;
        prev_valid <= o_valid;
    end

    function automatic logic [31:0] sx(input logic [23:0] w);
        return {{8{w[23]}}, w};
    endfunction

    function automatic logic bit_of(input logic [23:0] w, input int k);
        if (k < 24) return w[23-k];
        return 1'b1;
    endfunction

    // One SCK period of 16 tb_clk cycles; ws/sd change while SCK falls.
    task automatic send_bit(input logic ws_v, input logic sd_v);
        @(negedge tb_clk);
        sck = 1'b0;
        ws  = ws_v;
        sd  = sd_v;
        repeat (7) @(negedge tb_clk);
        @(negedge tb_clk);
        sck = 1'b1;
        last_rise = cyc + 1;
        repeat (7) @(negedge tb_clk);
    endtask

    task automatic send_slot(input logic ws_v, input logic [23:0] w, input int len);
        for (int k = 0; k < len; k++) begin
            send_bit((k == len - 1) ? ~ws_v : ws_v, bit_of(w, k));
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
        send_slot(1'b0, l, 32);
        send_slot(1'b1, r, 32);
    endtask

    task automatic expect_pair(input string tag, input logic [31:0] d, input logic [31:0] x);
        cap_t c;
        c = '{d: 32'h0, x: 32'h0, lat: 0};
        check({tag, "_count"}, 32'(capq.size()), 32'd1);
        if (capq.size() > 0) c = capq.pop_front();
        capq.delete();
        check({tag, "_d"}, c.d, d);
        check({tag, "_x"}, c.x, x);
        check({tag, "_lat"}, 32'(c.lat), 32'd4);
        last_d = d;
        last_x = x;
    endtask

    initial begin
        logic [23:0] rl, rr;
        int          e0;

        vecs[0] = '{24'h7FFFFF, 24'h800000, 32'h007FFFFF, 32'hFF800000};
        vecs[1] = '{24'h000000, 24'hFFFFFF, 32'h00000000, 32'hFFFFFFFF};
        vecs[2] = '{24'h123456, 24'h89ABCD, 32'h00123456, 32'hFF89ABCD};
        vecs[3] = '{24'h800001, 24'h7FFFFE, 32'hFF800001, 32'h007FFFFE};
        vecs[4] = '{24'hA5A5A5, 24'h5A5A5A, 32'hFFA5A5A5, 32'h005A5A5A};
        vecs[5] = '{24'h000001, 24'h400000, 32'h00000001, 32'h00400000};

        rst = 1'b1;
        sck = 1'b0;
        ws  = 1'b0;
        sd  = 1'b0;
        repeat (3) @(negedge tb_clk);
        check("rst_d", o_d, 32'h0);
        check("rst_x", o_x, 32'h0);
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_err", {31'b0, o_err}, 32'd0);
        rst = 1'b0;

        // Stream joins in the middle of a right slot.
        send_slot(1'b1, 24'hFFFFFF, 12);
        check("midstart_none", 32'(capq.size()), 32'd0);

        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].l, vecs[i].r);
            expect_pair($sformatf("vec%0d", i), vecs[i].d, vecs[i].x);
        end

        for (int i = 0; i < 16; i++) begin
            rl = 24'($urandom());
            rr = 24'($urandom());
            send_frame(rl, rr);
            expect_pair($sformatf("rand%0d", i), sx(rl), sx(rr));
        end

        // Reset for 3 cycles partway through a left slot.
        for (int k = 0; k < 10; k++) send_bit(1'b0, bit_of(24'h13579B, k));
        @(negedge tb_clk);
        rst = 1'b1;
        repeat (3) @(negedge tb_clk);
        check("midrst_d", o_d, 32'h0);
        check("midrst_x", o_x, 32'h0);
        check("midrst_valid", {31'b0, o_valid}, 32'd0);
        rst = 1'b0;
        for (int k = 10; k < 32; k++) send_bit((k == 31), bit_of(24'h13579B, k));
        send_slot(1'b1, 24'h2468AC, 32);
        check("postrst_none", 32'(capq.size()), 32'd0);
        send_frame(24'h0ABCDE, 24'hF12345);
        expect_pair("postrst", 32'h000ABCDE, 32'hFFF12345);

        // Right slot one SCK short.
        e0 = err_cnt;
        send_slot(1'b0, 24'h3C3C3C, 32);
        send_slot(1'b1, 24'hC3C3C3, 31);
`ifdef I2S_RX_FRAME_CHECK_EN
        check("short31_err", 32'(err_cnt - e0), 32'd1);
        check("short31_none", 32'(capq.size()), 32'd0);
        check("short31_hold_d", o_d, last_d);
        check("short31_hold_x", o_x, last_x);
`else
        check("short31_err", 32'(err_cnt - e0), 32'd0);
        expect_pair("short31", 32'h003C3C3C, 32'hFFC3C3C3);
`endif
        send_frame(24'h0F0F0F, 24'hF0F0F0);
        expect_pair("after31", 32'h000F0F0F, 32'hFFF0F0F0);

        // Right slot of 20 bits: sample LSBs zero-filled.
        e0 = err_cnt;
        send_slot(1'b0, 24'h654321, 32);
        send_slot(1'b1, 24'hABCDEF, 20);
`ifdef I2S_RX_FRAME_CHECK_EN
        check("pad20_err", 32'(err_cnt - e0), 32'd1);
        check("pad20_none", 32'(capq.size()), 32'd0);
        check("pad20_hold_d", o_d, last_d);
        check("pad20_hold_x", o_x, last_x);
`else
        check("pad20_err", 32'(err_cnt - e0), 32'd0);
        expect_pair("pad20", 32'h00654321, 32'hFFABCDE0);
`endif
        send_frame(24'h7FFFFF, 24'h800000);
        expect_pair("final", 32'h007FFFFF, 32'hFF800000);

`ifdef I2S_RX_FRAME_CHECK_EN
        check("err_total", 32'(err_cnt), 32'd2);
`else
        check("err_total", 32'(err_cnt), 32'd0);
`endif

        repeat (4) @(negedge tb_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_dual_rx.md
I2S_DUAL_RX -- requirements
Module: i2s_dual_rx

Interface
REQ-001 Parameter NB_DATA, default 32: width of o_d and o_x.
REQ-002 Parameter NB_SAMPLE, default 24: significant bits per microphone word (NB_SAMPLE <= NB_SLOT, NB_SAMPLE <= NB_DATA).
REQ-003 Parameter NB_SLOT, default 32: SCK periods per I2S half-frame.
REQ-004 i_clk  input  1  system clock, the only clock; all logic on its rising edge.
REQ-005 i_rst  input  1  synchronous, active-high reset.
REQ-006 i_sck  input  1  I2S bit clock, asynchronous to i_clk, frequency <= i_clk/4.
REQ-007 i_ws  input  1  I2S word select: 0 = left slot (MIC1), 1 = right slot (MIC2).
REQ-008 i_sd  input  1  I2S serial data, MSB first, one SCK delay after the WS transition.
REQ-009 o_d  output  NB_DATA  signed MIC1 sample, driving the adaptive filter's desired-signal input.
REQ-010 o_x  output  NB_DATA  signed MIC2 sample, driving the adaptive filter's reference input.
REQ-011 o_valid  output  1  one-i_clk pulse when o_d/o_x update as a pair.
REQ-012 o_err  output  1  one-i_clk pulse on a malformed half-frame (see Configuration).

Function
REQ-013 i_sck, i_ws and i_sd shall each pass through a 2-flop synchronizer; a further register shall detect SCK rising edges (sck_rise).
REQ-014 On each sck_rise the block shall shift synchronized sd into an NB_SLOT-bit shift register and compare synchronized ws with its value at the previous sck_rise.
REQ-015 FSM states: SYNC (after reset, discard data), LEFT, RIGHT.
REQ-016 SYNC->LEFT on the first sck_rise where ws changes 1->0; no word is latched on this transition.
REQ-017 LEFT->RIGHT on the sck_rise where ws changes 0->1: the bit shifted in on this edge is the last left bit; the left word shall be stored internally.
REQ-018 RIGHT->LEFT on the sck_rise where ws changes 1->0: the right word shall be completed, o_d/o_x shall be loaded with the pair, and o_valid shall pulse.
REQ-019 Word value: the first NB_SAMPLE bits received in the slot, sign-extended to NB_DATA; trailing slot bits are ignored.
REQ-020 Latency: o_valid shall rise exactly 4 i_clk cycles after the first i_clk edge that samples the raw i_sck high for the completing SCK edge.
REQ-021 o_d/o_x shall hold their value between o_valid pulses; o_valid shall never be high on two consecutive cycles.
REQ-022 A half-frame shorter than NB_SAMPLE SCK periods shall be zero-padded in its LSBs before sign extension.

Reset
REQ-023 While i_rst is high on a rising i_clk: o_d=0, o_x=0, o_valid=0, o_err=0, FSM=SYNC, synchronizers, shift register and slot counter cleared.
REQ-024 Reset asserted mid-frame shall discard the partial pair; after release no o_valid shall occur before a fresh 1->0 ws transition followed by a complete left+right frame.

Configuration
REQ-025 Macro I2S_RX_FRAME_CHECK_EN defined: a slot counter shall count sck_rise per half-frame; if the count at a ws transition differs from NB_SLOT, o_err shall pulse with the timing o_valid would have had, the pair in progress shall be discarded (no o_valid, o_d/o_x unchanged), and the FSM shall continue into the next slot normally.
REQ-026 Macro not defined: no slot counter is built, o_err shall be constant 0, and every complete left+right pair shall produce o_valid regardless of slot length.

Verification
REQ-027 i_clk 50 MHz, SCK 3.125 MHz, left word 0x7FFFFF, right word 0x800000 -> o_d=0x007FFFFF, o_x=0xFF800000, single o_valid pulse, latency per REQ-020.
REQ-028 Stream starting mid-right-slot -> no o_valid until the first complete left+right pair after the first ws 1->0 transition.
REQ-029 1000 frames of random 24-bit pairs -> o_d/o_x match the reference model bit-exactly on every o_valid; exactly 1000 pulses.
REQ-030 i_rst asserted for 3 cycles during the left slot -> outputs 0 during reset; the next o_valid carries only a post-reset frame.
REQ-031 With I2S_RX_FRAME_CHECK_EN, a right slot of 31 SCK periods -> one o_err pulse, no o_valid, o_d/o_x unchanged; the following good frame produces o_valid.
REQ-032 Without I2S_RX_FRAME_CHECK_EN, same 31-period stimulus -> o_err stays 0, o_valid pulses with the captured pair.
